multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// ============================================================================
//  Module      : multicycle_controller
//  Description : Moore FSM control unit for a multicycle RV32I datapath.
//                Sequences fetch/decode/execute/memory/writeback and drives
//                datapath selects, write enables and a sticky illegal flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
  parameter int EN_MEMWAIT = 1,
  parameter int EN_EXT     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       blt,
  input  logic       bltu,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       PCResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_ERROR    = 4'd15
  } state_t;

  localparam logic C_MEMWAIT = (EN_MEMWAIT != 0);
  localparam logic C_EXT     = (EN_EXT != 0);

  state_t     r_state;
  state_t     w_next;
  logic       w_ready;
  logic       w_taken;
  logic [2:0] w_alu_funct;
  logic       w_pcwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_memwrite;

  // Without the wait option the memory is assumed to complete every access.
  assign w_ready = C_MEMWAIT ? MemReady : 1'b1;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Branch condition selected by funct3; 010/011 are never taken.
  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = ~Zero;
      3'b100:  w_taken = blt;
      3'b101:  w_taken = ~blt;
      3'b110:  w_taken = bltu;
      3'b111:  w_taken = ~bltu;
      default: w_taken = 1'b0;
    endcase
  end

  // ALU operation for R/I-type execution; sub only for R-type with bit30.
  always_comb begin
    w_alu_funct = 3'b000;
    case (funct3)
      3'b000:        w_alu_funct = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
      3'b001, 3'b101: w_alu_funct = 3'b111;
      3'b010:        w_alu_funct = 3'b101;
      3'b011:        w_alu_funct = 3'b110;
      3'b100:        w_alu_funct = 3'b100;
      3'b110:        w_alu_funct = 3'b011;
      3'b111:        w_alu_funct = 3'b010;
      default:       w_alu_funct = 3'b000;
    endcase
  end

  // Immediate format depends only on the opcode, independent of state.
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      7'b0100011:             ImmSrc = 3'b001;
      7'b1100011:             ImmSrc = 3'b010;
      7'b1101111:             ImmSrc = 3'b011;
      7'b0110111, 7'b0010111: ImmSrc = 3'b100;
      default:                ImmSrc = 3'b000;
    endcase
  end

  // Next-state logic and Moore outputs; every output defaults to 0.
  always_comb begin
    w_next      = r_state;
    w_pcwrite   = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_memwrite  = 1'b0;
    AdrSrc      = 1'b0;
    PCResultSrc = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = 3'b000;
    ALUControl  = 3'b000;
    Illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 3'b010;
        w_irwrite = w_ready;
        w_pcwrite = w_ready;
        if (w_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXECR;
          7'b0010011:             w_next = S_EXECI;
          7'b1100011:             w_next = S_BRANCH;
          7'b1101111:             w_next = S_JAL;
          7'b1100111:             w_next = C_EXT ? S_JALR  : S_ERROR;
          7'b0110111:             w_next = C_EXT ? S_LUI   : S_ERROR;
          7'b0010111:             w_next = C_EXT ? S_AUIPC : S_ERROR;
          default:                w_next = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (w_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 3'b001;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
        if (w_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = w_alu_funct;
        w_next     = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = w_alu_funct;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 2'b10;
        ALUControl  = 3'b001;
        PCResultSrc = 1'b1;
        w_pcwrite   = w_taken;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        PCResultSrc = 1'b1;
        w_pcwrite   = 1'b1;
        ResultSrc   = 3'b100;
        w_regwrite  = 1'b1;
        w_next      = S_FETCH;
      end
      S_JALR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        w_pcwrite  = 1'b1;
        ResultSrc  = 3'b100;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_LUI: begin
        ResultSrc  = 3'b011;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_AUIPC: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_ERROR: begin
        Illegal = 1'b1;
        w_next  = S_ERROR;
      end
      default: begin
        w_next = S_ERROR;
      end
    endcase
  end

  // FETCH raises enables from MemReady alone, so gate them with reset to
  // guarantee no write can occur while reset is held.
  assign PCWrite  = w_pcwrite  & reset;
  assign IRWrite  = w_irwrite  & reset;
  assign RegWrite = w_regwrite & reset;
  assign MemWrite = w_memwrite & reset;
  assign State    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Directed self-checking bench for multicycle_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, blt, bltu, MemReady;

  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, PCResultSrc, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB;
  logic [2:0] ResultSrc, ImmSrc, ALUControl;
  logic [3:0] State;

  logic       n_PCWrite, n_IRWrite, n_RegWrite, n_MemWrite, n_AdrSrc, n_PCResultSrc, n_Illegal;
  logic [1:0] n_ALUSrcA, n_ALUSrcB;
  logic [2:0] n_ResultSrc, n_ImmSrc, n_ALUControl;
  logic [3:0] n_State;

  int chk_pass;
  int chk_total;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .blt(blt), .bltu(bltu), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .PCResultSrc(PCResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .Illegal(Illegal), .State(State)
  );

  // Variant without extension opcodes and without memory wait.
  multicycle_controller #(.EN_MEMWAIT(0), .EN_EXT(0)) dut_n (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .blt(blt), .bltu(bltu), .MemReady(MemReady),
    .PCWrite(n_PCWrite), .IRWrite(n_IRWrite), .RegWrite(n_RegWrite), .MemWrite(n_MemWrite),
    .AdrSrc(n_AdrSrc), .PCResultSrc(n_PCResultSrc), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB),
    .ResultSrc(n_ResultSrc), .ImmSrc(n_ImmSrc), .ALUControl(n_ALUControl),
    .Illegal(n_Illegal), .State(n_State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    MemReady = 1'b1;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; MemReady = 1'b1; op = 7'b0110011; funct3 = 3'b000;
    funct7b5 = 1'b0; Zero = 1'b0; blt = 1'b0; bltu = 1'b0;
    tick;
    chk_total++; if (State !== 4'd0) $display("FAIL reset_state: got %0d want 0", State); else chk_pass++;
    chk_total++; if (IRWrite !== 1'b0) $display("FAIL reset_irwrite: got %b want 0", IRWrite); else chk_pass++;
    chk_total++; if (PCWrite !== 1'b0) $display("FAIL reset_pcwrite: got %b want 0", PCWrite); else chk_pass++;
    chk_total++; if (Illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", Illegal); else chk_pass++;
    chk_total++; if (n_IRWrite !== 1'b0) $display("FAIL reset_irwrite_nowait: got %b want 0", n_IRWrite); else chk_pass++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_total++; if (IRWrite !== 1'b1) $display("FAIL fetch_irwrite: got %b want 1", IRWrite); else chk_pass++;
    tick;
    chk_total++; if (State !== 4'd1) $display("FAIL first_edge_decode: got %0d want 1", State); else chk_pass++;
  endtask

  task automatic test_lw;
    int exp_st [6] = '{0, 1, 2, 3, 4, 0};
    int exp_rw [6] = '{0, 0, 0, 0, 1, 0};
    do_reset;
    op = 7'b0000011;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick;
      chk_total++; if (State !== 4'(exp_st[i])) $display("FAIL lw_state[%0d]: got %0d want %0d", i, State, exp_st[i]); else chk_pass++;
      chk_total++; if (RegWrite !== 1'(exp_rw[i])) $display("FAIL lw_regwrite[%0d]: got %b want %0d", i, RegWrite, exp_rw[i]); else chk_pass++;
      if (exp_st[i] == 3) begin
        chk_total++; if (AdrSrc !== 1'b1) $display("FAIL lw_adrsrc: got %b want 1", AdrSrc); else chk_pass++;
      end
      if (exp_st[i] == 4) begin
        chk_total++; if (ResultSrc !== 3'b001) $display("FAIL lw_resultsrc: got %b want 001", ResultSrc); else chk_pass++;
      end
    end
  endtask

  task automatic test_sw_wait;
    do_reset;
    op = 7'b0100011;
    tick; tick;
    chk_total++; if (State !== 4'd2) $display("FAIL sw_memadr: got %0d want 2", State); else chk_pass++;
    chk_total++; if (ImmSrc !== 3'b001) $display("FAIL sw_immsrc: got %b want 001", ImmSrc); else chk_pass++;
    MemReady = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) MemReady = 1'b1;
      chk_total++; if (State !== 4'd5) $display("FAIL sw_wait_state[%0d]: got %0d want 5", i, State); else chk_pass++;
      chk_total++; if (MemWrite !== 1'b1) $display("FAIL sw_memwrite[%0d]: got %b want 1", i, MemWrite); else chk_pass++;
      tick;
    end
    chk_total++; if (State !== 4'd0) $display("FAIL sw_done_state: got %0d want 0", State); else chk_pass++;
    chk_total++; if (MemWrite !== 1'b0) $display("FAIL sw_done_memwrite: got %b want 0", MemWrite); else chk_pass++;
  endtask

  task automatic branch_case(input logic [2:0] f3, input logic z, input logic lt,
                             input logic ltu, input logic exp_pcw);
    do_reset;
    op = 7'b1100011; funct3 = f3; Zero = z; blt = lt; bltu = ltu;
    tick; tick;
    chk_total++; if (State !== 4'd9) $display("FAIL br_state f3=%b: got %0d want 9", f3, State); else chk_pass++;
    chk_total++; if (PCWrite !== exp_pcw) $display("FAIL br_pcwrite f3=%b z=%b lt=%b ltu=%b: got %b want %b", f3, z, lt, ltu, PCWrite, exp_pcw); else chk_pass++;
    chk_total++; if (ALUControl !== 3'b001 || PCResultSrc !== 1'b1 || ALUSrcA !== 2'b10)
      $display("FAIL br_ctrl: got alu=%b pcrs=%b srca=%b want 001 1 10", ALUControl, PCResultSrc, ALUSrcA); else chk_pass++;
    tick;
    chk_total++; if (State !== 4'd0) $display("FAIL br_return: got %0d want 0", State); else chk_pass++;
  endtask

  task automatic test_branch;
    branch_case(3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
    branch_case(3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
    branch_case(3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    branch_case(3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
    branch_case(3'b111, 1'b0, 1'b0, 1'b1, 1'b0);
    branch_case(3'b010, 1'b1, 1'b1, 1'b1, 1'b0);
    Zero = 1'b0; blt = 1'b0; bltu = 1'b0;
  endtask

  task automatic test_alu_ops;
    do_reset;
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    tick; tick;
    chk_total++; if (State !== 4'd6) $display("FAIL sub_state: got %0d want 6", State); else chk_pass++;
    chk_total++; if (ALUControl !== 3'b001) $display("FAIL sub_aluctl: got %b want 001", ALUControl); else chk_pass++;
    tick;
    chk_total++; if (State !== 4'd8 || RegWrite !== 1'b1 || ResultSrc !== 3'b000)
      $display("FAIL aluwb: got st=%0d rw=%b rs=%b want 8 1 000", State, RegWrite, ResultSrc); else chk_pass++;
    do_reset;
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    tick; tick;
    chk_total++; if (State !== 4'd7) $display("FAIL addi_state: got %0d want 7", State); else chk_pass++;
    chk_total++; if (ALUControl !== 3'b000) $display("FAIL addi_aluctl: got %b want 000", ALUControl); else chk_pass++;
    do_reset;
    op = 7'b0110011; funct3 = 3'b110; funct7b5 = 1'b0;
    tick; tick;
    chk_total++; if (ALUControl !== 3'b011) $display("FAIL or_aluctl: got %b want 011", ALUControl); else chk_pass++;
    do_reset;
    op = 7'b0010011; funct3 = 3'b011;
    tick; tick;
    chk_total++; if (ALUControl !== 3'b110) $display("FAIL sltiu_aluctl: got %b want 110", ALUControl); else chk_pass++;
    funct3 = 3'b000;
  endtask

  task automatic test_error;
    do_reset;
    op = 7'b1111111;
    tick; tick;
    for (int i = 0; i < 10; i++) begin
      chk_total++; if (State !== 4'd15 || Illegal !== 1'b1 || PCWrite !== 1'b0 || RegWrite !== 1'b0)
        $display("FAIL err_hold[%0d]: got st=%0d ill=%b pcw=%b rw=%b want 15 1 0 0", i, State, Illegal, PCWrite, RegWrite);
      else chk_pass++;
      tick;
    end
    reset = 1'b0;
    #1;
    chk_total++; if (State !== 4'd0 || Illegal !== 1'b0) $display("FAIL err_reset: got st=%0d ill=%b want 0 0", State, Illegal); else chk_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_jalr_ext;
    do_reset;
    op = 7'b1100111;
    tick; tick;
    chk_total++; if (State !== 4'd11) $display("FAIL jalr_state: got %0d want 11", State); else chk_pass++;
    chk_total++; if (PCWrite !== 1'b1 || RegWrite !== 1'b1 || ResultSrc !== 3'b100 || PCResultSrc !== 1'b0)
      $display("FAIL jalr_ctrl: got pcw=%b rw=%b rs=%b pcrs=%b want 1 1 100 0", PCWrite, RegWrite, ResultSrc, PCResultSrc);
    else chk_pass++;
    chk_total++; if (n_State !== 4'd15 || n_Illegal !== 1'b1) $display("FAIL jalr_noext: got st=%0d ill=%b want 15 1", n_State, n_Illegal); else chk_pass++;
    tick;
    chk_total++; if (State !== 4'd0) $display("FAIL jalr_return: got %0d want 0", State); else chk_pass++;
    do_reset;
    op = 7'b0110111;
    tick; tick;
    chk_total++; if (State !== 4'd12 || ResultSrc !== 3'b011 || ImmSrc !== 3'b100)
      $display("FAIL lui: got st=%0d rs=%b imm=%b want 12 011 100", State, ResultSrc, ImmSrc); else chk_pass++;
    do_reset;
    op = 7'b1101111;
    tick; tick;
    chk_total++; if (State !== 4'd10 || PCWrite !== 1'b1 || PCResultSrc !== 1'b1 || ResultSrc !== 3'b100)
      $display("FAIL jal: got st=%0d pcw=%b pcrs=%b rs=%b want 10 1 1 100", State, PCWrite, PCResultSrc, ResultSrc); else chk_pass++;
  endtask

  task automatic test_memwait;
    do_reset;
    op = 7'b0110011;
    MemReady = 1'b0;
    #1;
    chk_total++; if (IRWrite !== 1'b0 || n_IRWrite !== 1'b1) $display("FAIL wait_irwrite: got %b/%b want 0/1", IRWrite, n_IRWrite); else chk_pass++;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_total++; if (State !== 4'd0) $display("FAIL wait_hold[%0d]: got %0d want 0", i, State); else chk_pass++;
    end
    MemReady = 1'b1;
    tick;
    chk_total++; if (State !== 4'd1) $display("FAIL wait_release: got %0d want 1", State); else chk_pass++;
  endtask

  task automatic test_abort;
    do_reset;
    op = 7'b0000011;
    tick; tick; tick; tick;
    chk_total++; if (State !== 4'd4 || RegWrite !== 1'b1) $display("FAIL abort_pre: got st=%0d rw=%b want 4 1", State, RegWrite); else chk_pass++;
    reset = 1'b0;
    #1;
    chk_total++; if (State !== 4'd0 || RegWrite !== 1'b0 || IRWrite !== 1'b0 || PCWrite !== 1'b0)
      $display("FAIL abort_async: got st=%0d rw=%b ir=%b pcw=%b want 0 0 0 0", State, RegWrite, IRWrite, PCWrite);
    else chk_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    chk_pass  = 0;
    chk_total = 0;
    reset = 1'b0; MemReady = 1'b1; op = 7'b0; funct3 = 3'b0;
    funct7b5 = 1'b0; Zero = 1'b0; blt = 1'b0; bltu = 1'b0;
    test_reset;
    test_lw;
    test_sw_wait;
    test_branch;
    test_alu_ops;
    test_error;
    test_jalr_ext;
    test_memwait;
    test_abort;
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule

`default_nettype wire
